aes_inv_key_control: RTL and testbench
======================================

// Module: aes_inv_key_control
// PURPOSE
// Byte-serial inverse AES-128 key schedule for the decryption datapath.
// Accepts the round-10 key as 16 bytes, MSB byte first.
// Emits the round keys in reverse order (10 down to 0), each as a 16-byte stream.
// It is the reverse-direction partner of the forward byte-serial key controller.
// The decrypt round logic consumes round keys in exactly this order.
// PARAMETERS
// NB      16   bytes per key, fixed for AES-128 (not user-overridable in practice)
// NR      10   number of rounds; the first key streamed is round NR
// PORTS
// clk          in   1    clock, rising edge
// rst          in   1    asynchronous reset, active-low
// in_valid     in   1    in_key carries a valid byte
// in_key       in   8    round-10 key byte; byte 0 = key[127:120]
// in_ready     out  1    block can accept a key byte (LOAD state)
// out_valid    out  1    out_key carries a valid round-key byte
// out_key      out  8    current round-key byte, MSB byte first
// output_key1  out  128  full current round key {w0,w1,w2,w3}
// round        out  4    round index of the key being streamed (10..0)
// done         out  1    one-cycle pulse after the last byte of round 0
// BEHAVIOUR
// - Reset (rst=0, async) clears everything:
//   - state=LOAD, byte count=0, round=10.
//   - key register = 0, so output_key1 = 0.
//   - out_key=0, out_valid=0, done=0.
//   - in_ready=0 during reset; it goes to 1 on the first clk edge after release.
// - FSM states are LOAD, OUT and GEN.
// - LOAD:
//   - in_ready=1. A byte is accepted on an edge where in_valid=1, shifting into the low end.
//   - in_valid=0 cycles are gaps and are not counted.
//   - On the 16th accepted byte, the next edge enters OUT with round=10 and count=0, and in_ready drops to 0.
// - OUT:
//   - out_valid=1 for exactly 16 consecutive cycles; there is no output backpressure.
//   - out_key = byte[count] of the key register, byte 0 = [127:120].
//   - output_key1 and round are stable for all 16 cycles.
//   - First byte appears the cycle after the 16th input byte is accepted (latency 1).
//   - After byte 15: if round==0, go to LOAD, pulse done for 1 cycle, and set in_ready=1 that cycle.
//   - Otherwise go to GEN.
// - GEN: four cycles, one word per cycle, in this order:
//   - c0: w3 <= w3^w2
//   - c1: w2 <= w2^w1
//   - c2: w1 <= w1^w0
//   - c3: w0 <= w0 ^ SubWord(RotWord(w3)) ^ {Rcon(round),24'h0}; round <= round-1; go to OUT.
//   - Rcon(10..1) = 36,1b,80,40,20,10,08,04,02,01.
//   - SubWord uses an internal 256-entry combinational S-box function.
//   - out_valid=0 throughout GEN.
// - Per key, the output sequence is 11x16 OUT cycles plus 10x4 GEN cycles = 216 cycles from first out_valid to done.
// - in_valid outside LOAD is ignored; no bytes are captured.
// - Reset mid-operation aborts immediately. No partial key is retained, and the next key starts from byte 0.
// - round never wraps below 0. The round-0 key leaves OUT straight to LOAD, never to GEN.
// TESTING
// - Feed FIPS-197 round-10 key d014f9a8c9ee2589e13f0cc8b6630ca6:
//   - round=10 streams d0,14,..,a6.
//   - round=9 output_key1 = ac7766f319fadc2128d12941575c006e.
//   - round=1 output_key1 = a0fafe1788542cb123a339392a6c7605.
//   - round=0 output_key1 = 2b7e151628aed2a6abf7158809cf4f3c; done pulses once.
// - Feed b4ef5bcb3e92e21123e951cf6f8f188e -> round=0 key is all zero. Check 216 cycles from first out_valid to done.
// - Same FIPS key with in_valid=0 gaps inserted between bytes -> identical output; in_ready stays 1 through the gaps.
// - Toggle in_valid with garbage during OUT/GEN -> outputs unchanged; in_ready stays 0.
// - Assert rst at round=5 mid-stream:
//   - all outputs go to 0 asynchronously.
//   - in_ready=1 one edge after release.
//   - a fresh key then runs normally.
// - Back-to-back keys: a second key loaded right after done -> its round-10 bytes appear 1 cycle after its 16th byte.

Source files
------------

// File: rtl/aes_inv_key_control.sv
// Purpose: byte-serial inverse AES-128 key schedule; takes the round-10 key, streams round keys 10..0.
// Latency: first round-10 byte one cycle after the 16th input byte; 216 cycles from first out_valid to done.
// Backpressure: none on the output; in_ready is high only while a key is being loaded.
module aes_inv_key_control #(
  parameter int NB = 16,
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_key,
  output logic         in_ready,
  output logic         out_valid,
  output logic [7:0]   out_key,
  output logic [127:0] output_key1,
  output logic [3:0]   round,
  output logic         done
);

  typedef enum logic [1:0] {LOAD, OUT, GEN} state_t;

  // Forward AES S-box, row 0 in the most significant bits.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // Entry x sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
    sbox = SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Rcon of the forward step that produced round r; undoing it needs the same constant.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;      // byte index in LOAD/OUT, word step in GEN
  logic [3:0]     round_q, round_d;
  logic [127:0]   key_q, key_d;
  logic           done_q, done_d;
  logic           in_ready_q, in_ready_d;

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    sub_rot_w3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];
  // By step c3, w3 already holds the previous round's w3, which is what the forward step rotated.
  assign sub_rot_w3 = sub_word({w3[23:0], w3[31:24]});

  // Next-state logic: load bytes, stream the current key, then undo one forward expansion step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    key_d   = key_q;
    done_d  = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_valid) begin
          key_d = {key_q[119:0], in_key};
          if (cnt_q == 4'(NB - 1)) begin
            cnt_d   = 4'd0;
            round_d = 4'(NR);
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      OUT: begin
        if (cnt_q == 4'(NB - 1)) begin
          cnt_d = 4'd0;
          if (round_q == 4'd0) begin
            state_d = LOAD;
            done_d  = 1'b1;
          end else begin
            state_d = GEN;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      GEN: begin
        cnt_d = cnt_q + 4'd1;
        case (cnt_q[1:0])
          2'd0: key_d[31:0]  = w3 ^ w2;
          2'd1: key_d[63:32] = w2 ^ w1;
          2'd2: key_d[95:64] = w1 ^ w0;
          default: begin
            key_d[127:96] = w0 ^ sub_rot_w3 ^ {rcon(round_q), 24'h0};
            round_d       = round_q - 4'd1;
            cnt_d         = 4'd0;
            state_d       = OUT;
          end
        endcase
      end
      default: state_d = LOAD;
    endcase
    in_ready_d = (state_d == LOAD);
  end

  // State and datapath registers; reset aborts any key in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      cnt_q      <= 4'd0;
      round_q    <= 4'(NR);
      key_q      <= 128'h0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      round_q    <= round_d;
      key_q      <= key_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_valid   = (state_q == OUT);
  assign out_key     = out_valid ? key_q[{~cnt_q, 3'b000} +: 8] : 8'h00;
  assign output_key1 = key_q;
  assign round       = round_q;
  assign done        = done_q;
  assign in_ready    = in_ready_q;

endmodule

// File: tb/tb_aes_inv_key_control.sv
// Testbench for aes_inv_key_control: random and FIPS-197 keys checked against
// an array-based inverse key expansion with an S-box derived from GF(2^8) arithmetic.
module tb_aes_inv_key_control;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_key;
  logic         in_ready;
  logic         out_valid;
  logic [7:0]   out_key;
  logic [127:0] output_key1;
  logic [3:0]   round;
  logic         done;

  aes_inv_key_control dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_key(in_key),
    .in_ready(in_ready), .out_valid(out_valid), .out_key(out_key),
    .output_key1(output_key1), .round(round), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sbox_m  [256];
  logic [7:0]   rc_m    [11];
  logic [127:0] exp_rk  [11];
  logic [127:0] seen_rk [11];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15 - n -: 8];
  endfunction

  // S-box = affine(multiplicative inverse), inverse found by search.
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rc_m[0] = 8'h00;
    rc_m[1] = 8'h01;
    for (int j = 2; j <= 10; j++) rc_m[j] = xtime(rc_m[j-1]);
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r = {w[23:0], w[31:24]};
    return {sbox_m[r[31:24]], sbox_m[r[23:16]], sbox_m[r[15:8]], sbox_m[r[7:0]]};
  endfunction

  // Run the FIPS-197 word recurrence w[i] = w[i-4] ^ T(w[i-1]) backwards from w[40..43].
  task automatic compute_model(input logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    w[40] = k10[127:96]; w[41] = k10[95:64]; w[42] = k10[63:32]; w[43] = k10[31:0];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {rc_m[i/4], 24'h0};
      w[i-4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Called at a falling edge; leaves the bench at the falling edge after the 16th byte is taken.
  task automatic load_key(input logic [127:0] k, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        repeat (g) begin
          check("in_ready_gap", in_ready, 1);
          in_valid = 1'b0;
          in_key   = 8'($urandom);
          @(negedge clk);
        end
      end
      check("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_key   = k[127 - 8*i -: 8];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_key   = 8'h00;
  endtask

  // Walks the 216-cycle output schedule; abort_round >= 0 asserts reset mid-stream.
  task automatic stream(input bit garbage, input int abort_round, output bit aborted);
    aborted = 1'b0;
    check("first_byte_latency", out_valid, 1);
    for (int t = 0; t < 216; t++) begin
      int r   = 10 - t / 20;
      int pos = t % 20;
      if (r == abort_round && pos == 7) begin
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_key", out_key, 0);
        check("abort_key1", output_key1, 0);
        check("abort_done", done, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_round", round, 10);
        aborted = 1'b1;
        return;
      end
      if (pos < 16) begin
        check("out_valid_hi", out_valid, 1);
        check("out_key", out_key, exp_rk[r][127 - 8*pos -: 8]);
        check("round", round, r);
        check("output_key1", output_key1, exp_rk[r]);
        if (pos == 0) seen_rk[r] = output_key1;
      end else begin
        check("out_valid_gen", out_valid, 0);
      end
      check("done_early", done, 0);
      check("in_ready_busy", in_ready, 0);
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        in_key   = 8'($urandom);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_key   = 8'h00;
    check("done_at_216", done, 1);
    check("in_ready_at_done", in_ready, 1);
    check("out_valid_at_done", out_valid, 0);
  endtask

  task automatic full_key(input logic [127:0] k, input bit gaps, input bit garbage);
    bit ab;
    compute_model(k);
    load_key(k, gaps);
    stream(garbage, -1, ab);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, %0d miscompares so far", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ab;
    logic [127:0] k;
    rst = 1'b0; in_valid = 1'b0; in_key = 8'h00;
    build_tables();
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_key", out_key, 0);
    check("rst_key1", output_key1, 0);
    check("rst_done", done, 0);
    check("rst_round", round, 10);
    rst = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    // FIPS-197 known-answer run
    full_key(FIPS_K10, 1'b0, 1'b0);
    check("fips_r10", seen_rk[10], FIPS_K10);
    check("fips_r9", seen_rk[9], 128'hac7766f319fadc2128d12941575c006e);
    check("fips_r1", seen_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_r0", seen_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(negedge clk);
    check("done_single_pulse", done, 0);

    // All-zero cipher key
    full_key(ZERO_K10, 1'b0, 1'b0);
    check("zero_r0", seen_rk[0], 128'h0);
    @(negedge clk);

    // Input gaps plus garbage during OUT/GEN must not change anything
    full_key(FIPS_K10, 1'b1, 1'b1);
    check("fips_gaps_r0", seen_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(negedge clk);

    // Random keys
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      full_key(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end

    // Reset in the middle of round 5
    k = {$urandom, $urandom, $urandom, $urandom};
    compute_model(k);
    load_key(k, 1'b0);
    stream(1'b0, 5, ab);
    @(negedge clk);
    check("held_rst_key1", output_key1, 0);
    rst = 1'b1;
    #1 check("rst2_in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("rst2_in_ready_after_release", in_ready, 1);
    k = {$urandom, $urandom, $urandom, $urandom};
    full_key(k, 1'b1, 1'b0);

    // Back-to-back: next key loaded starting in the done cycle
    k = {$urandom, $urandom, $urandom, $urandom};
    full_key(k, 1'b0, 1'b0);
    full_key(FIPS_K10, 1'b0, 1'b1);
    check("b2b_fips_r0", seen_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(negedge clk);
    check("b2b_done_pulse", done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
